// File: rtl/instruction_prefetch_unit.sv
// Instruction prefetch unit: credit-limited sequential fetch into a {pc,data} FIFO.
// A redirect flushes the FIFO, restarts fetch and discards stale in-flight responses.
module instruction_prefetch_unit #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ready,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr_out,
  output logic [ADDR_W-1:0] instr_pc
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int OCC_W = CNT_W + 1;
  localparam logic [OCC_W-1:0] DEPTH_OCC = OCC_W'(DEPTH);

  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] resp_pc;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  inflight;
  logic [CNT_W-1:0]  discard;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [ADDR_W-1:0] pc_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];

  logic [OCC_W-1:0] occupancy;
  logic accept;
  logic rsp_push;
  logic rsp_drop;
  logic pop;

  // Both ports use strict valid/ready: a transfer happens only in a cycle where
  // valid and ready are both high; mem_addr is held while mem_req waits for mem_ready.
  // Issue is credit-limited: buffered plus outstanding fetches never exceed DEPTH.
  assign occupancy = {1'b0, count} + {1'b0, inflight};
  assign mem_req   = !reset && !redirect_valid && (occupancy < DEPTH_OCC);
  assign mem_addr  = fetch_pc;
  assign accept    = mem_req && mem_ready;

  assign rsp_push = !reset && mem_rvalid && !redirect_valid && (discard == '0);
  assign rsp_drop = mem_rvalid && !redirect_valid && (discard != '0);

  assign instr_valid = !reset && (count != '0);
  assign instr_out   = data_mem[rd_ptr];
  assign instr_pc    = pc_mem[rd_ptr];
  assign pop         = instr_valid && instr_ready && !redirect_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      resp_pc  <= RESET_PC;
      count    <= '0;
      inflight <= '0;
      discard  <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else begin
      inflight <= inflight + CNT_W'(accept) - CNT_W'(mem_rvalid);
      if (redirect_valid) begin
        // Everything still outstanding after this cycle's response belongs to the old stream.
        fetch_pc <= redirect_pc;
        resp_pc  <= redirect_pc;
        count    <= '0;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        discard  <= inflight - CNT_W'(mem_rvalid);
      end else begin
        if (accept) fetch_pc <= fetch_pc + ADDR_W'(1);
        if (rsp_drop) discard <= discard - CNT_W'(1);
        if (rsp_push) begin
          resp_pc <= resp_pc + ADDR_W'(1);
          wr_ptr  <= wr_ptr + PTR_W'(1);
        end
        if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
        case ({rsp_push, pop})
          2'b10:   count <= count + CNT_W'(1);
          2'b01:   count <= count - CNT_W'(1);
          default: count <= count;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rsp_push) begin
      pc_mem[wr_ptr]   <= resp_pc;
      data_mem[wr_ptr] <= mem_rdata;
    end
  end

endmodule
